// File: rtl/edge_pulse_pkg.sv
// edge_pulse_pkg: shared edge-mode encoding and debounce counter sizing
package edge_pulse_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/edge_pulse_channel.sv
// edge_pulse_channel: one synchronised, debounced edge detector with sticky pending flag
module edge_pulse_channel
    import edge_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw,
    input  edge_mode_t mode,
    input  logic       ack,
    output logic       pulse,
    output logic       level,
    output logic       event_pending
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   accept;
    logic                   fire;

    assign s      = sync[SYNC_STAGES-1];
    assign accept = (s != level) && (cnt == LAST);
    // mode is only looked at on the accepting edge, so it may change freely while counting
    assign fire   = accept && (s ? (mode == EDGE_RISE || mode == EDGE_BOTH)
                                 : (mode == EDGE_FALL || mode == EDGE_BOTH));

    // shift the raw input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    // count consecutive cycles of disagreement; accept the new level on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s == level) begin
            cnt <= '0;
        end else if (accept) begin
            cnt   <= '0;
            level <= s;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // one-cycle pulse on a qualifying accept; pending holds until acked, a new pulse beats the ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse         <= 1'b0;
            event_pending <= 1'b0;
        end else begin
            pulse         <= fire;
            event_pending <= fire | (event_pending & ~ack);
        end
    end

endmodule

// File: rtl/edge_pulse_bank.sv
// edge_pulse_bank: bank of independent debounced edge-pulse channels
module edge_pulse_bank
    import edge_pulse_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   input_signal,
    input  logic [2*CHANNELS-1:0] edge_mode,
    input  logic [CHANNELS-1:0]   event_ack,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   event_pending,
    output logic                  any_pulse
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("edge_pulse_bank: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("edge_pulse_bank: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("edge_pulse_bank: DEBOUNCE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_pulse_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .raw          (input_signal[i]),
            .mode         (edge_mode_t'(edge_mode[2*i +: 2])),
            .ack          (event_ack[i]),
            .pulse        (pulse[i]),
            .level        (level[i]),
            .event_pending(event_pending[i])
        );
    end

    assign any_pulse = |pulse;

endmodule

// File: tb/tb_edge_pulse_bank.sv
// tb_edge_pulse_bank: scoreboard bench for the debounced edge-pulse bank
module tb_edge_pulse_bank;

    logic       clk;
    logic       rst_n;
    logic [3:0] input_signal;
    logic [7:0] edge_mode;
    logic [3:0] event_ack;
    logic [3:0] pulse;
    logic [3:0] level;
    logic [3:0] event_pending;
    logic       any_pulse;

    typedef struct {
        int          cyc;
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    edge_pulse_bank #(
        .CHANNELS       (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_signal (input_signal),
        .edge_mode    (edge_mode),
        .event_ack    (event_ack),
        .pulse        (pulse),
        .level        (level),
        .event_pending(event_pending),
        .any_pulse    (any_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got pulse=%h level=%h pending=%h any=%b, expected pulse=%h level=%h pending=%h any=%b",
                     tag, cyc, got[12:9], got[8:5], got[4:1], got[0], exp[12:9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    // expected outputs k cycles from now, sampled on the falling edge of that cycle
    task automatic exp_at(input int k, input string tag, input logic [3:0] p, input logic [3:0] l, input logic [3:0] e);
        q.push_back('{cyc + k, tag, {p, l, e, |p}});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            chk(q[0].tag, {pulse, level, event_pending, any_pulse}, q[0].v);
            void'(q.pop_front());
        end
    end

    task automatic mode_run(input logic [7:0] m, input logic rise_p, input logic fall_p, input string tag);
        logic [3:0] rp;
        logic [3:0] fp;
        rp = rise_p ? 4'h4 : 4'h0;
        fp = fall_p ? 4'h4 : 4'h0;
        edge_mode    = m;
        input_signal = 4'h5;
        exp_at(6,  {tag, "_rise"},      rp,   4'h5, rp);
        exp_at(7,  {tag, "_rise_end"},  4'h0, 4'h5, rp);
        exp_at(16, {tag, "_fall"},      fp,   4'h1, rp | fp);
        exp_at(17, {tag, "_fall_end"},  4'h0, 4'h1, rp | fp);
        step(10);
        input_signal = 4'h1;
        step(10);
        event_ack = 4'h4;
        exp_at(1, {tag, "_ack"}, 4'h0, 4'h1, 4'h0);
        step(1);
        event_ack = 4'h0;
        step(2);
    endtask

    initial begin
        rst_n        = 1'b0;
        input_signal = 4'hF;
        edge_mode    = 8'h55;
        event_ack    = 4'h0;
        step(3);
        rst_n = 1'b1;
        exp_at(0, "reset_release", 4'h0, 4'h0, 4'h0);
        exp_at(5, "reset_pre",     4'h0, 4'h0, 4'h0);
        exp_at(6, "reset_rise",    4'hF, 4'hF, 4'hF);
        exp_at(7, "reset_rise_end",4'h0, 4'hF, 4'hF);
        step(8);
        event_ack = 4'hF;
        exp_at(1, "reset_ack", 4'h0, 4'hF, 4'h0);
        step(1);
        event_ack = 4'h0;
        step(2);
        input_signal = 4'h0;
        step(4);
        rst_n = 1'b0;
        exp_at(0, "rst_mid_debounce", 4'h0, 4'h0, 4'h0);
        step(2);
        rst_n = 1'b1;
        exp_at(0, "rst_mid_release", 4'h0, 4'h0, 4'h0);
        exp_at(6, "rst_mid_nopulse", 4'h0, 4'h0, 4'h0);
        exp_at(8, "rst_mid_quiet",   4'h0, 4'h0, 4'h0);
        step(10);
        input_signal = 4'h1;
        exp_at(5, "rise_pre",  4'h0, 4'h0, 4'h0);
        exp_at(6, "rise",      4'h1, 4'h1, 4'h1);
        exp_at(7, "rise_end",  4'h0, 4'h1, 4'h1);
        step(10);
        event_ack = 4'h1;
        exp_at(1, "rise_ack", 4'h0, 4'h1, 4'h0);
        step(1);
        event_ack = 4'h0;
        step(2);
        input_signal = 4'h3;
        exp_at(6, "glitch_none",  4'h0, 4'h1, 4'h0);
        exp_at(8, "glitch_quiet", 4'h0, 4'h1, 4'h0);
        step(3);
        input_signal = 4'h1;
        step(10);
        input_signal = 4'h3;
        exp_at(6,  "glitch4_accept", 4'h2, 4'h3, 4'h2);
        exp_at(7,  "glitch4_end",    4'h0, 4'h3, 4'h2);
        exp_at(11, "glitch4_fall",   4'h0, 4'h1, 4'h2);
        step(4);
        input_signal = 4'h1;
        step(10);
        event_ack = 4'h2;
        exp_at(1, "glitch_ack", 4'h0, 4'h1, 4'h0);
        step(1);
        event_ack = 4'h0;
        step(2);
        mode_run(8'h75, 1'b1, 1'b1, "both");
        mode_run(8'h65, 1'b0, 1'b1, "fall");
        mode_run(8'h45, 1'b0, 1'b0, "off");
        edge_mode    = 8'hC5;
        input_signal = 4'h9;
        exp_at(6,  "pend_first",     4'h8, 4'h9, 4'h8);
        exp_at(7,  "pend_hold",      4'h0, 4'h9, 4'h8);
        exp_at(16, "pend_ack_vs_set",4'h8, 4'h1, 4'h8);
        exp_at(17, "pend_after_set", 4'h0, 4'h1, 4'h8);
        exp_at(18, "pend_ack_alone", 4'h0, 4'h1, 4'h0);
        step(10);
        input_signal = 4'h1;
        step(5);
        event_ack = 4'h8;
        step(1);
        event_ack = 4'h0;
        step(1);
        event_ack = 4'h8;
        step(1);
        event_ack = 4'h0;
        step(2);
        edge_mode    = 8'h00;
        input_signal = 4'h0;
        exp_at(10, "conc_idle", 4'h0, 4'h0, 4'h0);
        step(12);
        edge_mode    = 8'hB1;
        input_signal = 4'hF;
        exp_at(6, "conc_rise",     4'h5, 4'hF, 4'h5);
        exp_at(7, "conc_rise_end", 4'h0, 4'hF, 4'h5);
        step(8);
        event_ack = 4'h1;
        exp_at(1, "conc_ack0", 4'h0, 4'hF, 4'h4);
        step(1);
        event_ack = 4'h0;
        step(1);
        input_signal = 4'h0;
        exp_at(6, "conc_fall",     4'hC, 4'h0, 4'hC);
        exp_at(7, "conc_fall_end", 4'h0, 4'h0, 4'hC);
        step(10);
        step(3);
        while (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: never sampled, expected %h at cyc %0d", q[0].tag, q[0].v, q[0].cyc);
            void'(q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
